rs_frame_reassembler: RTL and testbench
=======================================

// Module: rs_frame_reassembler
// PURPOSE
//  Downstream of the RS check-symbol remover. Consumes RS_K-byte decoded blocks, each carrying its own sof/eof.
//  Parses the 2-byte big-endian length header at the start of a frame and concatenates payload across blocks.
//  Discards the pad bytes in the last block. Buffers whole frames in a byte FIFO and presents them on a
//  valid/ready stream with sof/eof toward the MII TX side.
// PARAMETERS
//  RS_K      `RS_K  data bytes per RS block (input-side eof spacing)
//  LEN_W     16     width of the length header field
//  MAX_LEN   1518   largest legal payload length in bytes
//  FIFO_AW   11     FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  i_clk               in   1  system clock
//  i_rst               in   1  asynchronous reset, active-high
//  i_rs_re_data        in   8  decoded payload byte
//  i_rs_re_data_valid  in   1  byte strobe; no backpressure possible
//  i_rs_re_sof         in   1  first byte of a block; qualified by valid
//  i_rs_re_eof         in   1  last (RS_K-th) byte of a block; qualified by valid
//  o_frm_data          out  8  frame byte
//  o_frm_valid         out  1  o_frm_data is valid
//  i_frm_ready         in   1  sink accepts the byte when valid&ready
//  o_frm_sof           out  1  first payload byte of a frame
//  o_frm_eof           out  1  last payload byte of a frame
//  o_len_err           out  1  1-cycle pulse: header length is 0 or > MAX_LEN
//  o_frm_drop          out  1  1-cycle pulse: frame dropped for lack of FIFO space
//  o_frm_cnt           out 16  frames committed (see CONFIGURATION)
//  o_drop_cnt          out 16  frames dropped or rejected (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output is 0. FSM goes to IDLE, FIFO is emptied, counters clear. Reset mid-frame loses the partial frame.
//  Input FSM advances only on i_rs_re_data_valid:
//  - IDLE: sof -> latch byte as len[15:8], go to LEN_LO. Bytes without sof are ignored.
//  - LEN_LO: latch len[7:0], then:
//    - len==0 or len>MAX_LEN -> pulse o_len_err, go to PAD.
//    - len > FIFO free entries -> pulse o_frm_drop, go to DROP.
//    - otherwise go to PAYLOAD with rem=len.
//  - PAYLOAD: write {sof=first, eof=(rem==1), byte}; rem--. When rem reaches 0: go to IDLE if this byte had eof, else PAD.
//    In PAYLOAD and DROP, sof on a continuation block is ignored.
//  - DROP: same counting as PAYLOAD, but no writes.
//  - PAD: discard bytes until the eof byte, then go to IDLE. A sof seen in PAD is treated as a new frame header (IDLE rule).
//  - eof arriving in LEN_LO (RS_K<2 is illegal): treated as a header error.
//  The free-space check uses the free count in the LEN_LO cycle. Concurrent reads only add space, so no overflow is possible.
//  FIFO entry is 10 bits {sof,eof,data}. The output is a show-ahead register.
//  Latency: 2 clocks from the write of a byte to o_frm_valid when the FIFO is empty.
//  Handshake: o_frm_valid stays high and data/sof/eof stay stable until ready. Ready may be held low indefinitely.
//  Full FIFO with reads stalled: no writes occur beyond the reserved space.
//  Pointers are FIFO_AW+1 bits and wrap naturally. Full = MSBs differ, low bits equal.
//  Simultaneous read and write on an empty FIFO: the write lands, then the output appears the next cycle.
//  Counters saturate at 16'hFFFF.
// CONFIGURATION
//  REASM_STATS_EN defined:
//  - o_frm_cnt increments when a frame's eof byte is written.
//  - o_drop_cnt increments on o_len_err or o_frm_drop.
//  REASM_STATS_EN undefined: both counters are tied to 0 and no counter flops are built.
// STRUCTURE
//  Package rs_link_pkg: RS_K, LEN_W, MAX_LEN, HDR_BYTES=2, FSM state enum {IDLE,LEN_LO,PAYLOAD,DROP,PAD}.
//  Sub-module rs_reasm_fifo: 10-bit synchronous FIFO with show-ahead output and a free-count output.
//  The FSM and counters stay in the top module.
// TESTING
//  1. Single block, len=5, RS_K=16, bytes 00 05 A1..A5 + pad -> out A1..A5, sof on A1, eof on A5, pad bytes absent.
//  2. len=40 spanning 3 blocks (RS_K=16) -> 40 contiguous bytes out, one sof and one eof, continuation sofs ignored.
//  3. Header len=0, then len=1600 -> two o_len_err pulses, no output, the next valid frame is passed intact.
//  4. FIFO_AW=6, ready=0, frames len=40 then len=40 -> first stored, o_frm_drop on second.
//     Raise ready -> 40 bytes out, next frame accepted.
//  5. i_frm_ready toggling 1010 during a frame -> every byte seen exactly once, data held stable while stalled.
//  6. Assert i_rst mid-PAYLOAD -> outputs 0 next cycle, FIFO empty. Next frame len=3 -> output correct.

Source files
------------

// File: rtl/rs_link_pkg.sv
// Shared constants and FSM state type for the RS link receive path.
// RS_K comes from the `RS_K define (defaults to 16 when not set on the command line).
`ifndef RS_K
`define RS_K 16
`endif

package rs_link_pkg;
  localparam int RS_K      = `RS_K;
  localparam int LEN_W     = 16;
  localparam int MAX_LEN   = 1518;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    PAYLOAD,
    DROP,
    PAD
  } reasm_state_e;
endpackage

// File: rtl/rs_reasm_fifo.sv
// Synchronous FIFO with a show-ahead output register and a free-entry count.
// The shown entry stays counted as used until it is popped, so o_free covers all storage.
module rs_reasm_fifo
  import rs_link_pkg::*;
#(
  parameter int AW = 11,
  parameter int W  = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_ready,
  output logic          o_rd_valid,
  output logic [W-1:0]  o_rd_data,
  output logic [AW:0]   o_free
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  used;
  logic         full;
  logic         wr_fire;
  logic         pop;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;

  assign used    = wr_ptr_q - rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_free  = DEPTH_V - used;
  assign wr_fire = i_wr_en && !full;
  assign pop     = out_valid_q && i_rd_ready;

  // The output register always mirrors mem[rd_ptr]; a just-written entry
  // becomes visible one clock after its pointer update.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_fire};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    out_valid_d = (rd_ptr_d != wr_ptr_q);
    out_data_d  = mem_q[rd_ptr_d[AW-1:0]];
    if (out_valid_q && !pop) begin
      out_data_d = out_data_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_valid = out_valid_q;
  assign o_rd_data  = out_data_q;

endmodule

// File: rtl/rs_frame_reassembler.sv
// Rebuilds length-prefixed frames from RS_K-byte decoded blocks and streams them out.
// Define REASM_STATS_EN to build the committed/dropped frame counters.
module rs_frame_reassembler
  import rs_link_pkg::*;
#(
  parameter int LEN_W   = rs_link_pkg::LEN_W,
  parameter int MAX_LEN = rs_link_pkg::MAX_LEN,
  parameter int FIFO_AW = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rs_re_data,
  input  logic        i_rs_re_data_valid,
  input  logic        i_rs_re_sof,
  input  logic        i_rs_re_eof,
  output logic [7:0]  o_frm_data,
  output logic        o_frm_valid,
  input  logic        i_frm_ready,
  output logic        o_frm_sof,
  output logic        o_frm_eof,
  output logic        o_len_err,
  output logic        o_frm_drop,
  output logic [15:0] o_frm_cnt,
  output logic [15:0] o_drop_cnt
);

  logic [FIFO_AW:0] fifo_free;
  logic             fifo_valid;
  logic [9:0]       fifo_data;

  reasm_state_e     state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             wr_en_q, wr_en_d;
  logic [9:0]       wr_data_q, wr_data_d;
  logic             len_err_q, len_err_d;
  logic             frm_drop_q, frm_drop_d;

  logic [LEN_W-1:0] hdr_len;
  logic             hdr_bad;
  logic             hdr_nofit;
  logic             last_byte;

  assign hdr_len   = LEN_W'({len_hi_q, i_rs_re_data});
  assign hdr_bad   = (hdr_len == '0) || (32'(hdr_len) > 32'(MAX_LEN));
  assign hdr_nofit = 32'(hdr_len) > 32'(fifo_free);
  assign last_byte = (rem_q == LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    first_d    = first_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    len_err_d  = 1'b0;
    frm_drop_d = 1'b0;
    if (i_rs_re_data_valid) begin
      case (state_q)
        IDLE: begin
          if (i_rs_re_sof) begin
            len_hi_d = i_rs_re_data;
            state_d  = LEN_LO;
          end
        end
        LEN_LO: begin
          // A block ending inside the header cannot carry a frame.
          if (i_rs_re_eof) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else if (hdr_bad) begin
            len_err_d = 1'b1;
            state_d   = PAD;
          end else if (hdr_nofit) begin
            frm_drop_d = 1'b1;
            rem_d      = hdr_len;
            state_d    = DROP;
          end else begin
            rem_d   = hdr_len;
            first_d = 1'b1;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_data_d = {first_q, last_byte, i_rs_re_data};
          first_d   = 1'b0;
          rem_d     = rem_q - LEN_W'(1);
          if (last_byte) begin
            state_d = i_rs_re_eof ? IDLE : PAD;
          end
        end
        DROP: begin
          rem_d = rem_q - LEN_W'(1);
          if (last_byte) begin
            state_d = i_rs_re_eof ? IDLE : PAD;
          end
        end
        PAD: begin
          if (i_rs_re_sof) begin
            len_hi_d = i_rs_re_data;
            state_d  = LEN_LO;
          end else if (i_rs_re_eof) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      len_hi_q   <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      len_err_q  <= 1'b0;
      frm_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      len_err_q  <= len_err_d;
      frm_drop_q <= frm_drop_d;
    end
  end

  rs_reasm_fifo #(
    .AW (FIFO_AW),
    .W  (10)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (wr_en_q),
    .i_wr_data  (wr_data_q),
    .i_rd_ready (i_frm_ready),
    .o_rd_valid (fifo_valid),
    .o_rd_data  (fifo_data),
    .o_free     (fifo_free)
  );

  assign o_frm_valid = fifo_valid;
  assign o_frm_sof   = fifo_data[9];
  assign o_frm_eof   = fifo_data[8];
  assign o_frm_data  = fifo_data[7:0];
  assign o_len_err   = len_err_q;
  assign o_frm_drop  = frm_drop_q;

`ifdef REASM_STATS_EN
  logic [15:0] frm_cnt_q, frm_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    frm_cnt_d  = frm_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (wr_en_q && wr_data_q[8] && (frm_cnt_q != 16'hFFFF)) begin
      frm_cnt_d = frm_cnt_q + 16'd1;
    end
    if ((len_err_q || frm_drop_q) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      frm_cnt_q  <= frm_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_frm_cnt  = frm_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_frm_cnt  = '0;
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_frame_reassembler.sv
// Randomised frame stream against a queue-based frame model; a monitor pops and
// compares every accepted output byte and checks that stalled outputs hold.
module tb_rs_frame_reassembler;
  import rs_link_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int K     = RS_K;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rs_re_data = 8'h00;
  logic        i_rs_re_data_valid = 1'b0;
  logic        i_rs_re_sof = 1'b0;
  logic        i_rs_re_eof = 1'b0;
  logic [7:0]  o_frm_data;
  logic        o_frm_valid;
  logic        i_frm_ready;
  logic        o_frm_sof;
  logic        o_frm_eof;
  logic        o_len_err;
  logic        o_frm_drop;
  logic [15:0] o_frm_cnt;
  logic [15:0] o_drop_cnt;

  rs_frame_reassembler #(
    .FIFO_AW (AW)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_rs_re_data       (i_rs_re_data),
    .i_rs_re_data_valid (i_rs_re_data_valid),
    .i_rs_re_sof        (i_rs_re_sof),
    .i_rs_re_eof        (i_rs_re_eof),
    .o_frm_data         (o_frm_data),
    .o_frm_valid        (o_frm_valid),
    .i_frm_ready        (i_frm_ready),
    .o_frm_sof          (o_frm_sof),
    .o_frm_eof          (o_frm_eof),
    .o_len_err          (o_len_err),
    .o_frm_drop         (o_frm_drop),
    .o_frm_cnt          (o_frm_cnt),
    .o_drop_cnt         (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard state: expected {sof,eof,data} entries and event counts.
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int pushed = 0;
  int popped = 0;
  int len_err_exp = 0;
  int drop_exp = 0;
  int len_err_seen = 0;
  int drop_seen = 0;
  int frm_cnt_exp = 0;
  int drop_cnt_exp = 0;
  int rdy_mode = 0;
  logic       hold_pend = 1'b0;
  logic [9:0] hold_val = '0;

  task automatic check(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Sink ready: 0 = stalled, 1 = random, 2 = always, 3 = alternating 1010.
  initial begin
    i_frm_ready = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_frm_ready = 1'b0;
        1:       i_frm_ready = 1'($urandom_range(0, 1));
        2:       i_frm_ready = 1'b1;
        default: i_frm_ready = ~i_frm_ready;
      endcase
    end
  end

  initial begin : monitor
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        exp_q.delete();
        popped = 0;
        hold_pend = 1'b0;
      end else begin
        if (o_len_err) len_err_seen++;
        if (o_frm_drop) drop_seen++;
        got = {o_frm_sof, o_frm_eof, o_frm_data};
        if (hold_pend) begin
          check("stall_valid_held", o_frm_valid, 1);
          check("stall_data_held", got, hold_val);
        end
        hold_pend = 1'b0;
        if (o_frm_valid) begin
          if (i_frm_ready) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL spurious_byte: got 0x%0h expected none at %0t", got, $time);
            end else begin
              want = exp_q.pop_front();
              check("frm_byte", got, want);
              popped++;
            end
          end else begin
            hold_pend = 1'b1;
            hold_val  = got;
          end
        end
      end
    end
  end

  task automatic drive_idle();
    @(posedge i_clk);
    #1;
    i_rs_re_data_valid = 1'b0;
    i_rs_re_sof        = 1'b0;
    i_rs_re_eof        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
    if ($urandom_range(0, 3) == 0) drive_idle();
    @(posedge i_clk);
    #1;
    i_rs_re_data       = b;
    i_rs_re_data_valid = 1'b1;
    i_rs_re_sof        = s;
    i_rs_re_eof        = e;
  endtask

  task automatic check_status();
    check("len_err_pulses", len_err_seen, len_err_exp);
    check("frm_drop_pulses", drop_seen, drop_exp);
`ifdef REASM_STATS_EN
    check("frm_cnt", o_frm_cnt, frm_cnt_exp);
    check("drop_cnt", o_drop_cnt, drop_cnt_exp);
`else
    check("frm_cnt_tied", o_frm_cnt, 0);
    check("drop_cnt_tied", o_drop_cnt, 0);
`endif
  endtask

  // Stall the sink so occupancy is exact, then check the previous frame's effects.
  task automatic settle();
    rdy_mode = 0;
    drive_idle();
    repeat (4) @(posedge i_clk);
    #1;
    check_status();
  endtask

  // Sends one frame as whole RS_K blocks; cut >= 0 stops after that many bytes.
  task automatic send_frame(input int len, input int mode, input int cut);
    int occ;
    int nblk;
    bit bad;
    logic [7:0] pay[$];
    logic [7:0] b;
    settle();
    occ = pushed - popped;
    bad = (len == 0) || (len > MAX_LEN);
    if (bad) begin
      len_err_exp++;
      drop_cnt_exp++;
      nblk = 1;
    end else begin
      nblk = (HDR_BYTES + len + K - 1) / K;
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
      if (len > DEPTH - occ) begin
        drop_exp++;
        drop_cnt_exp++;
      end else begin
        for (int i = 0; i < len; i++) exp_q.push_back({(i == 0), (i == len - 1), pay[i]});
        pushed += len;
        frm_cnt_exp++;
      end
    end
    for (int j = 0; j < nblk * K; j++) begin
      if (cut >= 0 && j == cut) break;
      if (j == 0) b = 8'(len >> 8);
      else if (j == 1) b = 8'(len);
      else if (!bad && (j - 2) < len) b = pay[j - 2];
      else b = 8'($urandom_range(0, 255));
      send_byte(b, (j % K) == 0, (j % K) == K - 1);
      if (j == 1) rdy_mode = mode;
    end
    if (cut < 0) drive_idle();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    rdy_mode = 2;
    drive_idle();
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge i_clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(posedge i_clk);
    #1;
    check("drain_no_valid", o_frm_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst              = 1'b1;
    i_rs_re_data_valid = 1'b0;
    i_rs_re_sof        = 1'b0;
    i_rs_re_eof        = 1'b0;
    pushed             = 0;
    frm_cnt_exp        = 0;
    drop_cnt_exp       = 0;
    @(negedge i_clk);
    check("rst_valid", o_frm_valid, 0);
    check("rst_data", o_frm_data, 0);
    check("rst_sof_eof", {o_frm_sof, o_frm_eof}, 0);
    check("rst_pulses", {o_len_err, o_frm_drop}, 0);
    check("rst_frm_cnt", o_frm_cnt, 0);
    check("rst_drop_cnt", o_drop_cnt, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin : stimulus
    int r;
    int len;
    do_reset();
    // Short frame in one block, then one spanning three blocks.
    send_frame(5, 2, -1);
    send_frame(40, 1, -1);
    // Zero and oversize headers, then a good frame.
    send_frame(0, 2, -1);
    send_frame(1600, 2, -1);
    send_frame(20, 2, -1);
    wait_drain();
    // Stalled sink: first frame stored, second dropped, then accepted after drain.
    send_frame(40, 0, -1);
    send_frame(40, 0, -1);
    wait_drain();
    send_frame(40, 2, -1);
    wait_drain();
    // Exact fit fills the FIFO; a one-byte frame then has no room.
    send_frame(DEPTH, 0, -1);
    send_frame(1, 0, -1);
    wait_drain();
    send_frame(MAX_LEN + 1, 2, -1);
    send_frame(MAX_LEN, 2, -1);
    // Alternating ready during a frame.
    send_frame(30, 3, -1);
    // Reset in the middle of a payload, then a short frame.
    send_frame(30, 2, 12);
    do_reset();
    send_frame(3, 2, -1);
    wait_drain();
    for (int f = 0; f < 120; f++) begin
      r = $urandom_range(0, 19);
      if (r == 0) len = 0;
      else if (r == 1) len = MAX_LEN + 1 + $urandom_range(0, 3000);
      else if (r < 4) len = $urandom_range(DEPTH - 3, DEPTH + 6);
      else len = $urandom_range(1, DEPTH - 4);
      send_frame(len, $urandom_range(0, 3), -1);
      if ($urandom_range(0, 9) == 0) wait_drain();
      r = $urandom_range(0, 2);
      for (int n = 0; n < r; n++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    wait_drain();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
